// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD score accumulator.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         BCD_W    = 4;
  localparam logic [3:0] BCD_NINE = 4'd9;

  // True when a nibble is a legal decimal digit.
  function automatic logic bcd_digit_ok(input logic [BCD_W-1:0] d);
    return (d <= BCD_NINE);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder: binary add of two digits plus carry, then the
// classic decimal correction when the 5-bit result exceeds nine.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             cin,
  output logic [BCD_W-1:0] digit,
  output logic             cout
);

  logic [BCD_W:0] raw;
  logic [BCD_W:0] corrected;

  // Binary sum, then subtract ten and carry when it leaves the decimal range.
  always_comb begin
    raw       = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
    corrected = raw - 5'd10;
    if (raw > 5'd9) begin
      digit = corrected[BCD_W-1:0];
      cout  = 1'b1;
    end else begin
      digit = raw[BCD_W-1:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_accumulator.sv
// Multi-digit packed-BCD running total. Increments are added digit-serially
// through a single one-digit adder; the committed total only changes at the
// end of a full add, on clear, or on reset.
//
// Handshake: a request is taken on a rising edge where add_valid && ready.
// ready is a registered decode of the IDLE state, so it never depends on
// add_valid. Requests seen while ready is low are dropped, not queued.
// The FSM state is held in the internal signal `state` for checkers to bind.
module bcd_accumulator
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  add_valid,
  input  logic [4*DIGITS-1:0]   add_value,
  output logic                  ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  done,
  output logic                  overflow,
  output logic                  err
);

  localparam int               W        = BCD_W * DIGITS;
  localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [W-1:0]     ALL_NINES = {DIGITS{BCD_NINE}};

  state_t           state;
  logic [W-1:0]     operand;
  logic [W-1:0]     shadow;
  logic [W-1:0]     shadow_next;
  logic [IDX_W-1:0] idx;
  logic             carry;

  logic [BCD_W-1:0] cur_a;
  logic [BCD_W-1:0] cur_b;
  logic [BCD_W-1:0] dig_res;
  logic             dig_cout;
  logic             value_ok;

  // Select the current digit pair and build the shadow with that digit replaced.
  always_comb begin
    cur_a       = shadow[int'(idx)*BCD_W +: BCD_W];
    cur_b       = operand[int'(idx)*BCD_W +: BCD_W];
    shadow_next = shadow;
    shadow_next[int'(idx)*BCD_W +: BCD_W] = dig_res;
  end

  // A request is legal only when every nibble is a decimal digit.
  always_comb begin
    value_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_ok(add_value[i*BCD_W +: BCD_W])) value_ok = 1'b0;
    end
  end

  bcd_digit_add u_digit_add (
    .a     (cur_a),
    .b     (cur_b),
    .cin   (carry),
    .digit (dig_res),
    .cout  (dig_cout)
  );

  // Control FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sum      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      ready    <= 1'b1;
      operand  <= '0;
      shadow   <= '0;
      idx      <= '0;
      carry    <= 1'b0;
    end else if (clear) begin
      // Abort whatever is in flight; the working registers are left as-is
      // because they are reloaded on the next accepted request.
      state    <= IDLE;
      sum      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      ready    <= 1'b1;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (add_valid && ready) begin
            if (!value_ok) begin
              err <= 1'b1;
            end else begin
              operand <= add_value;
              shadow  <= sum;
              idx     <= '0;
              carry   <= 1'b0;
              state   <= RUN;
              ready   <= 1'b0;
            end
          end
        end
        RUN: begin
          shadow <= shadow_next;
          carry  <= dig_cout;
          idx    <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            // Commit edge: sum never sees the partially updated shadow.
            if (dig_cout) begin
              overflow <= 1'b1;
              sum      <= SATURATE ? ALL_NINES : shadow_next;
            end else begin
              sum <= shadow_next;
            end
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
